// File: rtl/stream_mux_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_mux_arb                                             |
// | Description : CHANNELS-to-1 valid/ready stream mux with fixed-select or  |
// |               round-robin arbitration and a registered output stage.     |
// |               Optional packet lock: define STREAM_MUX_PKT_LOCK_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_sel_in_range;
    logic             w_fix_found;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant;
    logic             w_xfer;
    logic             w_xfer_last;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             r_locked;
    logic [SEL_W-1:0] r_lock_chan;
`endif

    assign w_load_en = ~r_out_valid | out_ready;

    // Widen sel so the range test stays meaningful for non-power-of-two CHANNELS.
    assign w_sel_in_range = (32'(sel) < 32'(CHANNELS));
    assign w_fix_found    = w_sel_in_range && in_valid[sel];

    // Round-robin search starts just after the last granted channel.
    always_comb begin : p_rr_search
        int               w_pos;
        logic [SEL_W-1:0] w_idx;
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        w_pos      = 0;
        w_idx      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= CHANNELS) begin
                w_pos = w_pos - CHANNELS;
            end
            w_idx = SEL_W'(w_pos);
            if (!w_rr_found && in_valid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (r_locked) begin
            w_grant       = r_lock_chan;
            w_grant_valid = in_valid[r_lock_chan];
        end else
`endif
        if (mode) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_found;
        end else begin
            w_grant       = w_fix_found ? sel : '0;
            w_grant_valid = w_fix_found;
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && w_load_en && w_grant_valid) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    assign w_xfer = ~rst & w_load_en & w_grant_valid;

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign w_xfer_last = in_last[w_grant];
`else
    assign w_xfer_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_rr_ptr    <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_out_data  <= in_data[int'(w_grant)*WIDTH +: WIDTH];
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (mode && w_xfer_last) begin
                r_rr_ptr <= w_grant;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked    <= 1'b0;
            r_lock_chan <= '0;
        end else if (w_xfer) begin
            r_locked    <= ~w_xfer_last;
            r_lock_chan <= w_grant;
        end
    end
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stream_mux_arb                                          |
// | Description : Directed self-checking bench for stream_mux_arb.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stream_mux_arb;

    localparam int WIDTH = 32;
    localparam int CH    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [CH*WIDTH-1:0]   in_data;
    logic [CH-1:0]         in_valid;
    logic [CH-1:0]         in_ready;
    logic                  mode;
    logic [2:0]            sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            out_chan;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [CH-1:0]         in_last;
`endif

    // 16-channel instance for the in-range-but-idle select case
    logic [16*WIDTH-1:0]   in_data16;
    logic [15:0]           in_valid16;
    logic [15:0]           in_ready16;
    logic [3:0]            sel16;
    logic [WIDTH-1:0]      out_data16;
    logic                  out_valid16;
    logic [3:0]            out_chan16;

    // 5-channel instance for the out-of-range select case
    logic [5*WIDTH-1:0]    in_data5;
    logic [4:0]            in_valid5;
    logic [4:0]            in_ready5;
    logic [2:0]            sel5;
    logic [WIDTH-1:0]      out_data5;
    logic                  out_valid5;
    logic [2:0]            out_chan5;

    int errors = 0;
    int checks = 0;

    stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(16)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data16), .in_valid(in_valid16),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last({16{1'b1}}),
`endif
        .in_ready(in_ready16), .mode(mode), .sel(sel16), .out_data(out_data16),
        .out_valid(out_valid16), .out_ready(1'b1), .out_chan(out_chan16)
    );

    stream_mux_arb #(.WIDTH(WIDTH), .CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last({5{1'b1}}),
`endif
        .in_ready(in_ready5), .mode(mode), .sel(sel5), .out_data(out_data5),
        .out_valid(out_valid5), .out_ready(1'b1), .out_chan(out_chan5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; sel = 3'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
            checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
            checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_ready: got %h expected 00", in_ready); end
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 8'h01) begin errors++; $display("FAIL reset_first_grant: got %h expected 01", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", out_valid); end
        checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL reset_first_chan: got %0d expected 0", out_chan); end
        checks++; if (out_data !== 32'hA5A5_0000) begin errors++; $display("FAIL reset_first_data: got %h expected a5a50000", out_data); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        in_valid16 = 16'hFDFF; sel16 = 4'd9;
        in_valid5 = 5'h1F; sel5 = 3'd6;
        #1;
        checks++; if (in_ready !== 8'h20) begin errors++; $display("FAIL fixed_ready: got %h expected 20", in_ready); end
        checks++; if (in_ready16 !== 16'h0000) begin errors++; $display("FAIL fixed_idle_sel_ready: got %h expected 0000", in_ready16); end
        checks++; if (in_ready5 !== 5'h00) begin errors++; $display("FAIL fixed_oor_sel_ready: got %h expected 00", in_ready5); end
        sel16 = 4'd4;
        #1;
        checks++; if (in_ready16 !== 16'h0010) begin errors++; $display("FAIL fixed16_ready: got %h expected 0010", in_ready16); end
        tick();
        checks++; if (out_data !== 32'hA5A5_0005) begin errors++; $display("FAIL fixed_data: got %h expected a5a50005", out_data); end
        checks++; if (out_chan !== 3'd5) begin errors++; $display("FAIL fixed_chan: got %0d expected 5", out_chan); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid: got %b expected 1", out_valid); end
        in_valid16 = 16'h0000; in_valid5 = 5'h00;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [6] = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
        mode = 1'b1; in_valid = 8'b1001_0010; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_chan !== exp_seq[c]) begin errors++; $display("FAIL rr_chan[%0d]: got %0d expected %0d", c, out_chan, exp_seq[c]); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d]: got %h expected 00", c, in_ready); end
            tick();
            checks++; if (out_chan !== 3'd7 || out_data !== 32'hA5A5_0007 || out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold[%0d]: got chan=%0d data=%h valid=%b expected chan=7 data=a5a50007 valid=1", c, out_chan, out_data, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h02) begin errors++; $display("FAIL bp_release_ready: got %h expected 02", in_ready); end
        tick();
        checks++; if (out_chan !== 3'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got chan=%0d valid=%b expected chan=1 valid=1", out_chan, out_valid); end
    endtask

    task automatic test_wrap_idle();
        in_valid = 8'h80;
        tick();
        checks++; if (out_chan !== 3'd7) begin errors++; $display("FAIL wrap_setup_chan: got %0d expected 7", out_chan); end
        in_valid = 8'h01;
        #1;
        checks++; if (in_ready !== 8'h01) begin errors++; $display("FAIL wrap_ready: got %h expected 01", in_ready); end
        tick();
        checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL wrap_chan: got %0d expected 0", out_chan); end
        in_valid = 8'h00;
        #1;
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL idle_ready: got %h expected 00", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_drain_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0000 || out_chan !== 3'd0) begin errors++; $display("FAIL idle_hold: got data=%h chan=%0d expected a5a50000 chan=0", out_data, out_chan); end
    endtask

    task automatic test_mid_reset();
        in_valid = 8'h08;
        tick();
        checks++; if (out_chan !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_load: got chan=%0d valid=%b expected chan=3 valid=1", out_chan, out_valid); end
        out_ready = 1'b0; rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL midrst_discard: got valid=%b data=%h expected 0/0", out_valid, out_data); end
        rst = 1'b0; out_ready = 1'b1; in_valid = 8'hFF;
        #1;
        checks++; if (in_ready !== 8'h01) begin errors++; $display("FAIL midrst_ptr: got %h expected 01", in_ready); end
        in_valid = 8'h00;
        tick();
        tick();
    endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 8'b0000_1100; in_last = 8'h00;
        tick();
        checks++; if (out_chan !== 3'd2) begin errors++; $display("FAIL lock_beat1: got %0d expected 2", out_chan); end
        mode = 1'b0; sel = 3'd3;
        tick();
        checks++; if (out_chan !== 3'd2) begin errors++; $display("FAIL lock_beat2: got %0d expected 2", out_chan); end
        mode = 1'b1; in_last = 8'h04;
        tick();
        checks++; if (out_chan !== 3'd2) begin errors++; $display("FAIL lock_beat3: got %0d expected 2", out_chan); end
        in_last = 8'hFF;
        tick();
        checks++; if (out_chan !== 3'd3) begin errors++; $display("FAIL lock_release: got %0d expected 3", out_chan); end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        in_valid16 = '0; sel16 = '0; in_valid5 = '0; sel5 = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last = 8'hFF;
`endif
        for (int i = 0; i < CH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA5A5_0000 | 32'(i);
        for (int i = 0; i < 16; i++) in_data16[i*WIDTH +: WIDTH] = 32'hB0B0_0000 | 32'(i);
        for (int i = 0; i < 5; i++) in_data5[i*WIDTH +: WIDTH] = 32'hC0C0_0000 | 32'(i);

        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_wrap_idle();
        test_mid_reset();
`ifdef STREAM_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the team's combinational 8-to-1 bit mux.
- Selects one of CHANNELS input streams, each WIDTH bits wide with a valid/ready handshake, and forwards the chosen beat through a single registered output stage.
- Supports two modes: software-fixed select and fair round-robin arbitration.
- Sits between multiple producers (e.g. per-lane datapaths) and one shared downstream consumer.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 8, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SEL_W  source channel index of the current out_data.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - While rst=1 at a clk edge: out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1 (so channel 0 has first priority).
  - in_ready is all-zero during reset.
- Load enable:
  - load_en = ~out_valid | out_ready.
  - The output register accepts a new beat only when load_en=1.
- Grant (combinational, evaluated every cycle):
  - Fixed mode: grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant. Out-of-range sel never grants and never stalls other logic.
  - Round-robin mode: search channels rr_ptr+1, rr_ptr+2, ... modulo CHANNELS and grant the first with in_valid=1. No valid input means no grant.
- Ready:
  - in_ready[i] = load_en & grant_valid & (i==grant).
  - At most one bit of in_ready is set per cycle.
  - in_ready does not depend on in_valid of the granted channel beyond grant selection; no combinational path from out_data.
- Transfer:
  - A beat transfers when in_valid[g] & in_ready[g].
  - On the next edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In round-robin mode only, rr_ptr <= g.
- Drain: if out_valid & out_ready and no new transfer, out_valid <= 0. out_data and out_chan hold their last values.
- Latency: 1 cycle input-to-output. Full throughput of 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid are stable and all in_ready=0.
- Mode and sel changes: may occur on any cycle and take effect in the same cycle's grant. A beat already in the output register is unaffected.
- Pointer in fixed mode: rr_ptr does not advance.
- Wrap-around: the search from rr_ptr=CHANNELS-1 starts at channel 0.
- Mid-operation reset: any beat held in the output register is discarded.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds port in_last (input, CHANNELS bits).
  - After a transfer with in_last[g]=0, the grant is locked to g, ignoring mode, sel and rr search, until a transfer with in_last[g]=1 completes.
  - The lock is cleared by reset.
  - rr_ptr updates only on the transfer that carries last.
- Undefined: no in_last port; every beat is arbitrated independently.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout; first grant after release is channel 0 in round-robin mode.
- Fixed mode: mode=0, sel=5, in_valid=8'hFF, in_data[5]=32'hA5A5_0005, out_ready=1 -> in_ready=8'h20; next cycle out_data=32'hA5A5_0005, out_chan=5, out_valid=1. Then set sel=9 (CHANNELS=16 build, channel 9 invalid) -> in_ready=0.
- Round-robin fairness: mode=1, in_valid=8'b1001_0010, out_ready=1 for 6 cycles -> out_chan sequence 1,4,7,1,4,7.
- Backpressure: out_ready=0 for 4 cycles while out_valid=1 -> out_data/out_chan constant, in_ready=0. On out_ready=1 the next beat loads the same cycle, with no bubble.
- Wrap and idle: rr_ptr=7, only in_valid[0]=1 -> grant 0. Then all in_valid=0 with out_ready=1 -> out_valid drops after one cycle.
- With STREAM_MUX_PKT_LOCK_EN: channel 2 sends a 3-beat packet (last on beat 3) while channel 3 is valid -> out_chan=2,2,2, then 3.
